// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, functs, states and
// datapath select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnMult = 6'h18;
    localparam logic [5:0] FnDiv  = 6'h1A;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnAnd  = 6'h24;

    typedef enum logic [4:0] {
        StRst = 5'd0, StFetch, StFetchWr, StDecode, StExecR, StExecI, StWb,
        StMemAddr, StMemRd, StMemWb, StMemWr, StBranch, StJump, StJr,
        StMult, StDiv, StExc, StExcVec
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;

    localparam logic [2:0] PcSrcAlu    = 3'b000;
    localparam logic [2:0] PcSrcAluOut = 3'b001;
    localparam logic [2:0] PcSrcJump   = 3'b010;
    localparam logic [2:0] PcSrcReg    = 3'b011;
    localparam logic [2:0] PcSrcVec    = 3'b100;

    localparam logic [2:0] IordPc     = 3'b000;
    localparam logic [2:0] IordAluOut = 3'b001;

    localparam logic [2:0] RegDstRt = 3'b000;
    localparam logic [2:0] RegDstRd = 3'b001;
    localparam logic [2:0] RegDstRa = 3'b010;

    localparam logic [2:0] MemToRegAlu = 3'b000;
    localparam logic [2:0] MemToRegMem = 3'b001;
    localparam logic [2:0] MemToRegPc  = 3'b010;

    typedef enum logic [1:0] {
        ExcIllegal  = 2'b00,
        ExcOverflow = 2'b01,
        ExcDivZero  = 2'b10
    } exc_cause_e;

    // addiu and unsigned forms never trap on overflow.
    function automatic logic ovf_trap(input logic [5:0] op, input logic [5:0] funct);
        return (op == OpAddi) || (op == OpRtype && (funct == FnAdd || funct == FnSub));
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// 6-bit load/decrement counter; done_o is high while the count is zero.
module cycle_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [5:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [5:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && count_q != 6'd0) begin
            count_d = count_q - 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 6'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 6'd0);

endmodule

// File: rtl/control_fsm_mc.sv
// Multicycle MIPS control FSM with memory wait states, MULT/DIV stalls and a precise
// exception path (illegal opcode, overflow, divide-by-zero).
module control_fsm_mc
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT    = 1,
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter bit          EXC_ENABLE  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_zero,
    output logic       RegWrite,
    output logic       IrWrite,
    output logic       PcWrite,
    output logic       PcWriteCond,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       EpcWrite,
    output logic       AluOutWrite,
    output logic       MultControl,
    output logic       DivControl,
    output logic [1:0] AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] AluOp,
    output logic [2:0] PcSource,
    output logic [2:0] Iord,
    output logic [2:0] RegDst,
    output logic [2:0] MemToReg,
    output logic [1:0] ExcCause,
    output logic [4:0] state_o
);

    state_e     state_d, state_q;
    logic [1:0] cause_d, cause_q;
    exc_cause_e exc_next;
    logic       cnt_load, cnt_done;
    logic [5:0] cnt_val;
    logic       is_rtype;

    // Branch polarity is resolved in the datapath: PC enable = PcWrite | (PcWriteCond & taken).
    logic unused_zero;
    assign unused_zero = zero;

    assign is_rtype = (op == OpRtype);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        exc_next = ExcIllegal;
        case (state_q)
            StRst:     state_d = StFetch;
            StFetch:   if (cnt_done) state_d = StFetchWr;
            StFetchWr: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpRtype: begin
                        case (funct)
                            FnAdd, FnSub, FnAnd: state_d = StExecR;
                            FnMult:              state_d = StMult;
                            FnJr:                state_d = StJr;
                            FnDiv: begin
                                if (div_zero && EXC_ENABLE) begin
                                    state_d  = StExc;
                                    exc_next = ExcDivZero;
                                end else begin
                                    state_d = StDiv;
                                end
                            end
                            default: state_d = EXC_ENABLE ? StExc : StFetch;
                        endcase
                    end
                    OpAddi, OpAddiu: state_d = StExecI;
                    OpLw, OpSw:      state_d = StMemAddr;
                    OpBeq, OpBne:    state_d = StBranch;
                    OpJ, OpJal:      state_d = StJump;
                    default:         state_d = EXC_ENABLE ? StExc : StFetch;
                endcase
            end
            StExecR, StExecI: begin
                if (EXC_ENABLE && overflow && ovf_trap(op, funct)) begin
                    state_d  = StExc;
                    exc_next = ExcOverflow;
                end else begin
                    state_d = StWb;
                end
            end
            StWb:      state_d = StFetch;
            StMemAddr: state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (cnt_done) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StJr:      state_d = StFetch;
            StMult:    if (cnt_done) state_d = StFetch;
            StDiv:     if (cnt_done) state_d = StFetch;
            StExc:     state_d = StExcVec;
            StExcVec:  state_d = StFetch;
            default:   state_d = StRst;
        endcase
        if (state_d == StExc && state_q != StExc) begin
            cause_d = exc_next;
        end
    end

    // Counter reloads on every state change, so a stalling state lasts load value + 1 cycles.
    assign cnt_load = (state_d != state_q);

    always_comb begin
        case (state_d)
            StFetch, StMemRd: cnt_val = 6'(MEM_WAIT);
            StMult:           cnt_val = 6'(MULT_CYCLES - 1);
            StDiv:            cnt_val = 6'(DIV_CYCLES - 1);
            default:          cnt_val = 6'd0;
        endcase
    end

    cycle_counter u_cycle_counter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (!cnt_load),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRst;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        RegWrite    = 1'b0;
        IrWrite     = 1'b0;
        PcWrite     = 1'b0;
        PcWriteCond = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        EpcWrite    = 1'b0;
        AluOutWrite = 1'b0;
        MultControl = 1'b0;
        DivControl  = 1'b0;
        AluSrcA     = 2'b00;
        AluSrcB     = 2'b00;
        AluOp       = AluAdd;
        PcSource    = PcSrcAlu;
        Iord        = IordPc;
        RegDst      = RegDstRt;
        MemToReg    = MemToRegAlu;
        case (state_q)
            StFetch: MemRead = 1'b1;
            StFetchWr: begin
                IrWrite = 1'b1;
                PcWrite = 1'b1;
                AluSrcB = 2'b01;
            end
            StDecode: begin
                AluOutWrite = 1'b1;
                AluSrcB     = 2'b11;
            end
            StExecR: begin
                AluSrcA     = 2'b01;
                AluOutWrite = 1'b1;
                case (funct)
                    FnSub:   AluOp = AluSub;
                    FnAnd:   AluOp = AluAnd;
                    default: AluOp = AluAdd;
                endcase
            end
            StExecI: begin
                AluSrcA     = 2'b01;
                AluSrcB     = 2'b10;
                AluOutWrite = 1'b1;
            end
            StWb: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype ? RegDstRd : RegDstRt;
            end
            StMemAddr: begin
                AluOutWrite = 1'b1;
                AluSrcA     = 2'b01;
                AluSrcB     = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                Iord    = IordAluOut;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemToReg = MemToRegMem;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                Iord     = IordAluOut;
            end
            StBranch: begin
                AluSrcA     = 2'b01;
                AluOp       = AluSub;
                PcWriteCond = 1'b1;
                PcSource    = PcSrcAluOut;
            end
            StJump: begin
                PcWrite  = 1'b1;
                PcSource = PcSrcJump;
                if (op == OpJal) begin
                    RegWrite = 1'b1;
                    RegDst   = RegDstRa;
                    MemToReg = MemToRegPc;
                end
            end
            StJr: begin
                PcWrite  = 1'b1;
                PcSource = PcSrcReg;
            end
            StMult: MultControl = 1'b1;
            StDiv:  DivControl  = 1'b1;
            StExc: begin
                EpcWrite = 1'b1;
                AluSrcB  = 2'b01;
                AluOp    = AluSub;
            end
            StExcVec: begin
                PcWrite  = 1'b1;
                PcSource = PcSrcVec;
            end
            default: ;
        endcase
    end

    assign ExcCause = cause_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_control_fsm_mc.sv
// Directed bench for control_fsm_mc: instruction vector table plus hand-written reset,
// MULT/DIV and timing sequences.
module tb_control_fsm_mc;
    import mips_ctrl_pkg::*;

    localparam int unsigned MemWait    = 2;
    localparam int unsigned MultCycles = 12;
    localparam int unsigned DivCycles  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, overflow, div_zero;
    logic       RegWrite, IrWrite, PcWrite, PcWriteCond, MemRead, MemWrite, EpcWrite;
    logic       AluOutWrite, MultControl, DivControl;
    logic [1:0] AluSrcA, AluSrcB, ExcCause;
    logic [2:0] AluOp, PcSource, Iord, RegDst, MemToReg;
    logic [4:0] state_o;

    control_fsm_mc #(
        .MEM_WAIT    (MemWait),
        .MULT_CYCLES (MultCycles),
        .DIV_CYCLES  (DivCycles),
        .EXC_ENABLE  (1'b1)
    ) dut (
        .clk (clk), .reset (reset), .op (op), .funct (funct), .zero (zero),
        .overflow (overflow), .div_zero (div_zero), .RegWrite (RegWrite),
        .IrWrite (IrWrite), .PcWrite (PcWrite), .PcWriteCond (PcWriteCond),
        .MemRead (MemRead), .MemWrite (MemWrite), .EpcWrite (EpcWrite),
        .AluOutWrite (AluOutWrite), .MultControl (MultControl), .DivControl (DivControl),
        .AluSrcA (AluSrcA), .AluSrcB (AluSrcB), .AluOp (AluOp), .PcSource (PcSource),
        .Iord (Iord), .RegDst (RegDst), .MemToReg (MemToReg), .ExcCause (ExcCause),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    logic [28:0] outs;
    assign outs = {RegWrite, IrWrite, PcWrite, PcWriteCond, MemRead, MemWrite, EpcWrite,
                   AluOutWrite, MultControl, DivControl, AluSrcA, AluSrcB, AluOp, PcSource,
                   Iord, RegDst, MemToReg};

    localparam logic [28:0] BitRw  = 29'd1 << 28;
    localparam logic [28:0] BitPcw = 29'd1 << 26;
    localparam logic [28:0] BitPcc = 29'd1 << 25;
    localparam logic [28:0] BitMr  = 29'd1 << 24;
    localparam logic [28:0] BitMw  = 29'd1 << 23;
    localparam logic [28:0] BitEpc = 29'd1 << 22;
    localparam logic [28:0] BitAow = 29'd1 << 21;
    localparam logic [28:0] All    = '1;
    localparam logic [28:0] NoAsa  = ~(29'd3 << 17);
    localparam logic [28:0] NoAsb  = ~(29'd3 << 15);

    function automatic logic [28:0] f_asa(input logic [1:0] v); return 29'(v) << 17; endfunction
    function automatic logic [28:0] f_asb(input logic [1:0] v); return 29'(v) << 15; endfunction
    function automatic logic [28:0] f_aop(input logic [2:0] v); return 29'(v) << 12; endfunction
    function automatic logic [28:0] f_pcs(input logic [2:0] v); return 29'(v) << 9;  endfunction
    function automatic logic [28:0] f_iod(input logic [2:0] v); return 29'(v) << 6;  endfunction
    function automatic logic [28:0] f_rd(input logic [2:0] v);  return 29'(v) << 3;  endfunction
    function automatic logic [28:0] f_m2r(input logic [2:0] v); return 29'(v);       endfunction

    typedef struct {
        logic [5:0]      op;
        logic [5:0]      funct;
        logic            zero;
        logic            ovf;
        logic            dz;
        logic [4:0][4:0] path;  // states after DECODE, StFetch pads
        int              key;   // path index whose outputs are compared
        logic [28:0]     exp;
        logic [28:0]     mask;
        logic            chk_cause;
        logic [1:0]      cause;
    } vec_t;

    function automatic vec_t mkv(input logic [5:0] vop, input logic [5:0] vfn,
                                 input logic z, input logic ovf, input logic dz,
                                 input state_e p0, input state_e p1, input state_e p2,
                                 input state_e p3, input state_e p4, input int key,
                                 input logic [28:0] exp, input logic [28:0] mask,
                                 input logic chk, input logic [1:0] cause);
        vec_t v;
        v.op = vop; v.funct = vfn; v.zero = z; v.ovf = ovf; v.dz = dz;
        v.path[0] = p0; v.path[1] = p1; v.path[2] = p2; v.path[3] = p3; v.path[4] = p4;
        v.key = key; v.exp = exp; v.mask = mask; v.chk_cause = chk; v.cause = cause;
        return v;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Entered with the DUT in its first FETCH cycle; leaves it in the next one.
    task automatic run_vec(input int idx, input vec_t v);
        op = v.op; funct = v.funct; zero = v.zero; overflow = v.ovf; div_zero = v.dz;
        for (int k = 0; k < 1 + int'(MemWait); k++) begin
            check($sformatf("v%0d fetch%0d", idx, k), 32'(state_o), 32'(StFetch));
            @(negedge clk);
        end
        check($sformatf("v%0d fetch_wr", idx), 32'(state_o), 32'(StFetchWr));
        @(negedge clk);
        check($sformatf("v%0d decode", idx), 32'(state_o), 32'(StDecode));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (v.path[k] == StFetch) break;
            check($sformatf("v%0d state%0d", idx, k), 32'(state_o), 32'(v.path[k]));
            if (k == v.key) begin
                check($sformatf("v%0d outputs", idx), 32'(outs & v.mask), 32'(v.exp));
            end
            @(negedge clk);
        end
        check($sformatf("v%0d back_to_fetch", idx), 32'(state_o), 32'(StFetch));
        if (v.chk_cause) check($sformatf("v%0d exc_cause", idx), 32'(ExcCause), 32'(v.cause));
    endtask

    vec_t vecs[18];
    int   fetch_n, ir_n, rw_cyc, cnt;
    logic [2:0] rd_seen;

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0; div_zero = 1'b0;

        vecs[0]  = mkv(OpRtype, FnAdd, 1'b0, 1'b0, 1'b0, StExecR, StWb, StFetch, StFetch,
                       StFetch, 0, BitAow | f_asa(2'b01) | f_aop(3'b000), NoAsb, 1'b0, 2'b00);
        vecs[1]  = mkv(OpRtype, FnSub, 1'b0, 1'b0, 1'b0, StExecR, StWb, StFetch, StFetch,
                       StFetch, 0, BitAow | f_asa(2'b01) | f_aop(3'b001), NoAsb, 1'b0, 2'b00);
        vecs[2]  = mkv(OpRtype, FnAnd, 1'b0, 1'b0, 1'b0, StExecR, StWb, StFetch, StFetch,
                       StFetch, 0, BitAow | f_asa(2'b01) | f_aop(3'b010), NoAsb, 1'b0, 2'b00);
        vecs[3]  = mkv(OpAddi, 6'h00, 1'b0, 1'b0, 1'b0, StExecI, StWb, StFetch, StFetch,
                       StFetch, 1, BitRw | f_rd(3'b000), All, 1'b0, 2'b00);
        vecs[4]  = mkv(OpAddiu, 6'h00, 1'b0, 1'b1, 1'b0, StExecI, StWb, StFetch, StFetch,
                       StFetch, 1, BitRw | f_rd(3'b000), All, 1'b0, 2'b00);
        vecs[5]  = mkv(OpRtype, FnAdd, 1'b0, 1'b1, 1'b0, StExecR, StExc, StExcVec, StFetch,
                       StFetch, 1, BitEpc | f_asb(2'b01) | f_aop(3'b001), All, 1'b1, 2'b01);
        vecs[6]  = mkv(OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StMemAddr, StMemRd, StMemRd, StMemRd,
                       StMemWb, 4, BitRw | f_rd(3'b000) | f_m2r(3'b001), All, 1'b0, 2'b00);
        vecs[7]  = mkv(OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StMemAddr, StMemRd, StMemRd, StMemRd,
                       StMemWb, 3, BitMr | f_iod(3'b001), All, 1'b0, 2'b00);
        vecs[8]  = mkv(OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StMemAddr, StMemWr, StFetch, StFetch,
                       StFetch, 1, BitMw | f_iod(3'b001), All, 1'b0, 2'b00);
        vecs[9]  = mkv(OpBeq, 6'h00, 1'b1, 1'b0, 1'b0, StBranch, StFetch, StFetch, StFetch,
                       StFetch, 0, BitPcc | f_aop(3'b001) | f_pcs(3'b001), NoAsa & NoAsb,
                       1'b0, 2'b00);
        vecs[10] = mkv(OpBeq, 6'h00, 1'b0, 1'b0, 1'b0, StBranch, StFetch, StFetch, StFetch,
                       StFetch, 0, BitPcc | f_aop(3'b001) | f_pcs(3'b001), NoAsa & NoAsb,
                       1'b0, 2'b00);
        vecs[11] = mkv(OpBne, 6'h00, 1'b0, 1'b0, 1'b0, StBranch, StFetch, StFetch, StFetch,
                       StFetch, 0, BitPcc | f_aop(3'b001) | f_pcs(3'b001), NoAsa & NoAsb,
                       1'b0, 2'b00);
        vecs[12] = mkv(OpJ, 6'h00, 1'b0, 1'b0, 1'b0, StJump, StFetch, StFetch, StFetch,
                       StFetch, 0, BitPcw | f_pcs(3'b010), All, 1'b0, 2'b00);
        vecs[13] = mkv(OpJal, 6'h00, 1'b0, 1'b0, 1'b0, StJump, StFetch, StFetch, StFetch,
                       StFetch, 0, BitPcw | f_pcs(3'b010) | BitRw | f_rd(3'b010) | f_m2r(3'b010),
                       All, 1'b0, 2'b00);
        vecs[14] = mkv(OpRtype, FnJr, 1'b0, 1'b0, 1'b0, StJr, StFetch, StFetch, StFetch,
                       StFetch, 0, BitPcw | f_pcs(3'b011), All, 1'b0, 2'b00);
        vecs[15] = mkv(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, StExc, StExcVec, StFetch, StFetch,
                       StFetch, 1, BitPcw | f_pcs(3'b100), All, 1'b1, 2'b00);
        vecs[16] = mkv(OpRtype, FnDiv, 1'b0, 1'b0, 1'b1, StExc, StExcVec, StFetch, StFetch,
                       StFetch, 0, BitEpc | f_asb(2'b01) | f_aop(3'b001), All, 1'b1, 2'b10);
        vecs[17] = mkv(OpRtype, 6'h3F, 1'b0, 1'b0, 1'b0, StExc, StExcVec, StFetch, StFetch,
                       StFetch, 0, BitEpc | f_asb(2'b01) | f_aop(3'b001), All, 1'b1, 2'b00);

        // Reset state, then first edge after release enters FETCH.
        #1;
        check("reset state", 32'(state_o), 32'(StRst));
        check("reset outputs", 32'(outs), 32'd0);
        check("reset cause", 32'(ExcCause), 32'd0);
        repeat (2) @(negedge clk);
        check("reset held", 32'(state_o), 32'(StRst));
        reset = 1'b1;
        @(negedge clk);
        check("release fetch", 32'(state_o), 32'(StFetch));
        check("release memread", 32'(MemRead), 32'd1);

        // add timing: FETCH for 3 cycles, one IrWrite, RegWrite in cycle 7 with RegDst=rd.
        op = OpRtype; funct = FnAdd; overflow = 1'b0;
        fetch_n = 0; ir_n = 0; rw_cyc = 0; rd_seen = 3'b111;
        for (int c = 1; c <= 7; c++) begin
            if (state_o == StFetch) fetch_n++;
            if (IrWrite) ir_n++;
            if (RegWrite) begin
                rw_cyc  = c;
                rd_seen = RegDst;
            end
            @(negedge clk);
        end
        check("add fetch cycles", 32'(fetch_n), 32'd3);
        check("add irwrite count", 32'(ir_n), 32'd1);
        check("add regwrite cycle", 32'(rw_cyc), 32'd7);
        check("add regdst", 32'(rd_seen), 32'd1);
        check("add next fetch", 32'(state_o), 32'(StFetch));

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // MULT: MultControl high exactly MultCycles cycles, then FETCH.
        op = OpRtype; funct = FnMult; overflow = 1'b0; div_zero = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5 + int'(MultCycles); c++) begin
            if (MultControl) cnt++;
            @(negedge clk);
        end
        check("mult cycles", 32'(cnt), 32'(MultCycles));
        check("mult done fetch", 32'(state_o), 32'(StFetch));

        // DIV with nonzero divisor: DivControl high exactly DivCycles cycles.
        funct = FnDiv; div_zero = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5 + int'(DivCycles); c++) begin
            if (DivControl) cnt++;
            @(negedge clk);
        end
        check("div cycles", 32'(cnt), 32'(DivCycles));
        check("div done fetch", 32'(state_o), 32'(StFetch));
        check("cause held", 32'(ExcCause), 32'd0);

        // Reset asserted in MULT cycle 5 clears everything at once.
        funct = FnMult;
        repeat (9) @(negedge clk);
        check("mult running", 32'(MultControl), 32'd1);
        reset = 1'b0;
        #1;
        check("midmult reset outputs", 32'(outs), 32'd0);
        check("midmult reset state", 32'(state_o), 32'(StRst));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midmult release fetch", 32'(state_o), 32'(StFetch));
        check("midmult release memread", 32'(MemRead), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
